// File: rtl/branch_resolve_unit_if.sv
// Fetch/execute <-> branch resolve unit bundle.
// BRU_STATS_EN adds the statistics counters.
interface branch_resolve_unit_if #(
    parameter int PC_W = 32
);
    logic            push_valid;
    logic            push_ready;
    logic [PC_W-1:0] push_pc;
    logic            push_pred_valid;
    logic            push_pred_taken;
    logic [PC_W-1:0] push_pred_target;
    logic            res_valid;
    logic            res_ready;
    logic            res_taken;
    logic [PC_W-1:0] res_target;
    logic            update_enable;
    logic [PC_W-1:0] update_pc;
    logic            update_taken;
    logic [PC_W-1:0] update_target;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [PC_W-1:0] redirect_pc;
    logic            err_underflow;
`ifdef BRU_STATS_EN
    logic [31:0]     stat_branches;
    logic [31:0]     stat_mispred;
`endif

    modport master (
        output push_valid, push_pc, push_pred_valid,
        output push_pred_taken, push_pred_target,
        output res_valid, res_taken, res_target,
        output redirect_ready,
        input  push_ready, res_ready,
        input  update_enable, update_pc, update_taken, update_target,
        input  redirect_valid, redirect_pc, err_underflow
`ifdef BRU_STATS_EN
        , input stat_branches, stat_mispred
`endif
    );

    modport slave (
        input  push_valid, push_pc, push_pred_valid,
        input  push_pred_taken, push_pred_target,
        input  res_valid, res_taken, res_target,
        input  redirect_ready,
        output push_ready, res_ready,
        output update_enable, update_pc, update_taken, update_target,
        output redirect_valid, redirect_pc, err_underflow
`ifdef BRU_STATS_EN
        , output stat_branches, stat_mispred
`endif
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// In-order branch prediction checker: predictor update + fetch redirect.
// Define BRU_STATS_EN to add branch / mispredict counters.
module branch_resolve_unit #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 32
) (
    input logic                  clk,
    input logic                  rst,
    branch_resolve_unit_if.slave io
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic {RUN, RECOVER} state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_mem  [DEPTH];
    logic [PC_W-1:0] tgt_mem [DEPTH];
    logic [DEPTH-1:0] pv_mem, pt_mem;
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            redir_q, redir_d;
    logic [PC_W-1:0] rpc_q, rpc_d;
    logic            upd_en_q, upd_taken_q, err_q;
    logic [PC_W-1:0] upd_pc_q, upd_tgt_q;

    logic            full, empty, push_fire, res_fire;
    logic            pv_h, pt_h, pred_p, mispred;
    logic [PC_W-1:0] pc_h, tgt_h, upd_tgt;

    assign full      = cnt_q == (AW+1)'(DEPTH);
    assign empty     = cnt_q == '0;
    assign io.push_ready = !full && state_q == RUN;
    assign io.res_ready  = !empty && state_q == RUN;
    assign push_fire = io.push_valid && io.push_ready;
    assign res_fire  = io.res_valid && io.res_ready;

    assign pc_h   = pc_mem[rd_q];
    assign tgt_h  = tgt_mem[rd_q];
    assign pv_h   = pv_mem[rd_q];
    assign pt_h   = pt_mem[rd_q];
    // A BTB miss counts as a not-taken prediction
    assign pred_p  = pv_h & pt_h;
    assign mispred = (pred_p != io.res_taken) |
                     (pred_p & io.res_taken & (tgt_h != io.res_target));
    assign upd_tgt = io.res_taken ? io.res_target :
                     (pv_h ? tgt_h : io.res_target);

    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        redir_d = redir_q;
        rpc_d   = rpc_q;
        unique case (state_q)
            RUN: begin
                if (push_fire) wr_d = wr_q + 1'b1;
                if (res_fire)  rd_d = rd_q + 1'b1;
                cnt_d = cnt_q + (AW+1)'(push_fire)
                              - (AW+1)'(res_fire);
                // Everything younger than a mispredict is wrong path
                if (res_fire && mispred) begin
                    state_d = RECOVER;
                    wr_d    = '0;
                    rd_d    = '0;
                    cnt_d   = '0;
                    redir_d = 1'b1;
                    rpc_d   = io.res_taken ? io.res_target
                                           : pc_h + PC_W'(4);
                end
            end
            RECOVER: begin
                if (redir_q && io.redirect_ready) begin
                    state_d = RUN;
                    redir_d = 1'b0;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            pc_mem[wr_q]  <= io.push_pc;
            tgt_mem[wr_q] <= io.push_pred_target;
            pv_mem[wr_q]  <= io.push_pred_valid;
            pt_mem[wr_q]  <= io.push_pred_taken;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            wr_q        <= '0;
            rd_q        <= '0;
            cnt_q       <= '0;
            redir_q     <= 1'b0;
            rpc_q       <= '0;
            upd_en_q    <= 1'b0;
            upd_taken_q <= 1'b0;
            upd_pc_q    <= '0;
            upd_tgt_q   <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            rd_q     <= rd_d;
            cnt_q    <= cnt_d;
            redir_q  <= redir_d;
            rpc_q    <= rpc_d;
            upd_en_q <= res_fire;
            if (res_fire) begin
                upd_pc_q    <= pc_h;
                upd_taken_q <= io.res_taken;
                upd_tgt_q   <= upd_tgt;
            end
            if (io.res_valid && empty && state_q == RUN)
                err_q <= 1'b1;
        end
    end

    assign io.update_enable  = upd_en_q;
    assign io.update_pc      = upd_pc_q;
    assign io.update_taken   = upd_taken_q;
    assign io.update_target  = upd_tgt_q;
    assign io.redirect_valid = redir_q;
    assign io.redirect_pc    = rpc_q;
    assign io.err_underflow  = err_q;

`ifdef BRU_STATS_EN
    logic [31:0] br_q, mp_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_q <= '0;
            mp_q <= '0;
        end else if (res_fire) begin
            if (br_q != 32'hFFFF_FFFF) br_q <= br_q + 32'd1;
            if (mispred && mp_q != 32'hFFFF_FFFF)
                mp_q <= mp_q + 32'd1;
        end
    end

    assign io.stat_branches = br_q;
    assign io.stat_mispred  = mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit with an update scoreboard.
// Build with BRU_STATS_EN to also check the statistics counters.
module tb_branch_resolve_unit;
    localparam int DEPTH = 8;
    localparam int PC_W  = 32;

    typedef struct {
        logic [31:0] pc;
        bit          pv;
        bit          pt;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        bit          taken;
        logic [31:0] tgt;
    } upd_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    branch_resolve_unit_if #(.PC_W(PC_W)) bus ();

    branch_resolve_unit #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    ent_t        mq[$];
    upd_t        expq[$];
    bit          rec = 0;
    bit          err_m = 0;
    logic [31:0] rpc_exp = '0;
    int          n_br = 0;
    int          n_mp = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && bus.update_enable === 1'b1) begin
            if (expq.size() == 0) begin
                chk("upd_unexpected", 1, 0);
            end else begin
                upd_t e;
                e = expq.pop_front();
                chk("upd_pc", bus.update_pc, e.pc);
                chk("upd_taken", bus.update_taken, e.taken);
                chk("upd_target", bus.update_target, e.tgt);
            end
        end
    end

    task automatic drive_idle();
        bus.push_valid       = 0;
        bus.push_pc          = '0;
        bus.push_pred_valid  = 0;
        bus.push_pred_taken  = 0;
        bus.push_pred_target = '0;
        bus.res_valid        = 0;
        bus.res_taken        = 0;
        bus.res_target       = '0;
        bus.redirect_ready   = 0;
    endtask

    task automatic step(input bit pv_, input logic [31:0] ppc,
                        input bit ppv, input bit ppt,
                        input logic [31:0] ptgt, input bit rv,
                        input bit rt, input logic [31:0] rtgt,
                        input bit rr);
        bit pr, rsr, pf, rf, p, m;
        ent_t h, n;
        @(negedge clk);
        pr  = (mq.size() < DEPTH) && !rec;
        rsr = (mq.size() != 0) && !rec;
        chk("push_ready", bus.push_ready, pr);
        chk("res_ready", bus.res_ready, rsr);
        chk("redirect_valid", bus.redirect_valid, rec);
        if (rec) chk("redirect_pc", bus.redirect_pc, rpc_exp);
        chk("err_underflow", bus.err_underflow, err_m);
        bus.push_valid       = pv_;
        bus.push_pc          = ppc;
        bus.push_pred_valid  = ppv;
        bus.push_pred_taken  = ppt;
        bus.push_pred_target = ptgt;
        bus.res_valid        = rv;
        bus.res_taken        = rt;
        bus.res_target       = rtgt;
        bus.redirect_ready   = rr;
        pf = pv_ && pr;
        rf = rv && rsr;
        m  = 0;
        if (rv && mq.size() == 0 && !rec) err_m = 1;
        if (rec) begin
            if (rr) rec = 0;
        end else begin
            if (rf) begin
                h = mq.pop_front();
                p = h.pv && h.pt;
                m = (p != rt) || (p && rt && h.tgt != rtgt);
                expq.push_back('{pc: h.pc, taken: rt,
                    tgt: rt ? rtgt : (h.pv ? h.tgt : rtgt)});
                n_br++;
                if (m) begin
                    n_mp++;
                    rec = 1;
                    rpc_exp = rt ? rtgt : h.pc + 32'd4;
                    mq.delete();
                end
            end
            if (pf && !m) begin
                n = '{pc: ppc, pv: ppv, pt: ppt, tgt: ptgt};
                mq.push_back(n);
            end
        end
        @(posedge clk);
    endtask

    task automatic push(input logic [31:0] pc, input bit pv,
                        input bit pt, input logic [31:0] tgt);
        step(1, pc, pv, pt, tgt, 0, 0, '0, 0);
    endtask

    task automatic resolve(input bit rt, input logic [31:0] rtgt);
        step(0, '0, 0, 0, '0, 1, rt, rtgt, 0);
    endtask

    task automatic idle(input bit rr);
        step(0, '0, 0, 0, '0, 0, 0, '0, rr);
    endtask

    task automatic resolve_ok();
        bit t;
        t = mq[0].pv && mq[0].pt;
        resolve(t, t ? mq[0].tgt : 32'h0BAD_0000);
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive_idle();
        rst = 1;
        @(posedge clk);
        mq.delete();
        expq.delete();
        rec = 0;
        err_m = 0;
        n_br = 0;
        n_mp = 0;
        @(negedge clk);
        chk("rst_push_ready", bus.push_ready, 1);
        chk("rst_res_ready", bus.res_ready, 0);
        chk("rst_update_en", bus.update_enable, 0);
        chk("rst_redirect", bus.redirect_valid, 0);
        chk("rst_err", bus.err_underflow, 0);
`ifdef BRU_STATS_EN
        chk("rst_stat_br", bus.stat_branches, 0);
        chk("rst_stat_mp", bus.stat_mispred, 0);
`endif
        rst = 0;
    endtask

    initial begin
        drive_idle();
        repeat (2) @(posedge clk);
        do_reset();

        // BTB miss resolved taken
        push(32'h100, 0, 0, '0);
        resolve(1, 32'h200);
        idle(0);
        idle(0);
        chk("t1_redirect_pc", bus.redirect_pc, 32'h200);
        idle(1);
        idle(0);

        // correct taken prediction
        push(32'h40, 1, 1, 32'h80);
        resolve(1, 32'h80);
        idle(0);
        idle(0);

        // predicted taken, resolved not taken, younger entries flushed
        push(32'h40, 1, 1, 32'h80);
        push(32'h50, 0, 0, '0);
        push(32'h60, 0, 0, '0);
        step(1, 32'h70, 0, 0, '0, 1, 0, '0, 0);
        idle(0);
        chk("t3_redirect_pc", bus.redirect_pc, 32'h44);
        idle(0);
        idle(1);
        idle(0);
        idle(0);

        // fill, push blocked on full, then pointer wrap
        for (int i = 0; i < DEPTH; i++)
            push(32'h1000 + 32'(i * 4), 0, 0, '0);
        idle(0);
        step(1, 32'h2000, 0, 0, '0, 1, 0, 32'h0BAD_0000, 0);
        chk("t4_count7", mq.size(), 7);
        for (int i = 0; i < 20; i++) begin
            bit t;
            t = mq[0].pv && mq[0].pt;
            step(1, 32'h3000 + 32'(i * 4), i[0], 1,
                 32'h5000 + 32'(i * 8), 1, t,
                 t ? mq[0].tgt : 32'h0BAD_0000, 0);
        end
        for (int i = 0; i < DEPTH && mq.size() > 0; i++)
            resolve_ok();
        idle(0);
        idle(0);

        // resolve on empty queue
        resolve(1, 32'h300);
        idle(0);
        idle(0);
        chk("t5_err_sticky", bus.err_underflow, 1);

        // reset while recovering
        push(32'h700, 1, 1, 32'h900);
        resolve(0, '0);
        idle(0);
        do_reset();
        idle(0);

        // 5 branches, 2 mispredicts
        push(32'h40, 1, 1, 32'h80);
        resolve(1, 32'h80);
        push(32'h44, 0, 0, '0);
        resolve(0, '0);
        push(32'h48, 1, 1, 32'h80);
        resolve(1, 32'h90);
        idle(0);
        idle(1);
        push(32'h90, 1, 0, 32'hA0);
        resolve(0, '0);
        push(32'h94, 1, 1, 32'hC0);
        resolve(0, '0);
        idle(0);
        idle(1);
        idle(0);
`ifdef BRU_STATS_EN
        chk("stat_branches", bus.stat_branches, 5);
        chk("stat_mispred", bus.stat_mispred, 2);
        chk("stat_br_model", bus.stat_branches, 32'(n_br));
        chk("stat_mp_model", bus.stat_mispred, 32'(n_mp));
`endif
        idle(0);
        chk("scoreboard_drained", expq.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_mis);
        $finish;
    end
endmodule
